// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: joystick bits, scancodes,
// key-state indices and the rotate encoding.
package arcade_input_pkg;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_FIRE  = 4;
    localparam int JOY_START = 5;
    localparam int JOY_COIN  = 7;
    localparam int JOY_AUTO  = 8;

    localparam logic [8:0] SC_P1_UP    = 9'h175;
    localparam logic [8:0] SC_P1_DOWN  = 9'h172;
    localparam logic [8:0] SC_P1_LEFT  = 9'h16B;
    localparam logic [8:0] SC_P1_RIGHT = 9'h174;
    localparam logic [8:0] SC_P2_UP    = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT  = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT = 9'h034;
    localparam logic [8:0] SC_P2_FIRE  = 9'h01C;
    localparam logic [8:0] SC_START1_A = 9'h016;
    localparam logic [8:0] SC_START1_B = 9'h005;
    localparam logic [8:0] SC_START2_A = 9'h01E;
    localparam logic [8:0] SC_START2_B = 9'h006;
    localparam logic [8:0] SC_COIN0    = 9'h02E;
    localparam logic [8:0] SC_COIN1    = 9'h036;
    localparam logic [8:0] SC_TEST     = 9'h02C;

    localparam int K_P1_UP    = 0;
    localparam int K_P1_DOWN  = 1;
    localparam int K_P1_LEFT  = 2;
    localparam int K_P1_RIGHT = 3;
    localparam int K_P1_FIREA = 4;
    localparam int K_P1_FIREB = 5;
    localparam int K_P2_UP    = 6;
    localparam int K_P2_DOWN  = 7;
    localparam int K_P2_LEFT  = 8;
    localparam int K_P2_RIGHT = 9;
    localparam int K_P2_FIRE  = 10;
    localparam int K_S1A      = 11;
    localparam int K_S1B      = 12;
    localparam int K_S2A      = 13;
    localparam int K_S2B      = 14;
    localparam int K_COIN0    = 15;
    localparam int K_COIN1    = 16;
    localparam int K_TEST     = 17;
    localparam int K_NUM      = 18;

    // Single-player builds drop every player-2 key and coin1.
    localparam logic [K_NUM-1:0] P1_ONLY_MASK = 18'b1_0_1_1111_00000_111111;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    function automatic logic [K_NUM-1:0] key_decode(input logic [8:0] sc);
        logic [K_NUM-1:0] hit;
        hit = '0;
        casez (sc)
            SC_P1_UP:        hit[K_P1_UP]    = 1'b1;
            SC_P1_DOWN:      hit[K_P1_DOWN]  = 1'b1;
            SC_P1_LEFT:      hit[K_P1_LEFT]  = 1'b1;
            SC_P1_RIGHT:     hit[K_P1_RIGHT] = 1'b1;
            9'b?_0010_1001:  hit[K_P1_FIREA] = 1'b1;
            9'b?_0001_0100:  hit[K_P1_FIREB] = 1'b1;
            SC_P2_UP:        hit[K_P2_UP]    = 1'b1;
            SC_P2_DOWN:      hit[K_P2_DOWN]  = 1'b1;
            SC_P2_LEFT:      hit[K_P2_LEFT]  = 1'b1;
            SC_P2_RIGHT:     hit[K_P2_RIGHT] = 1'b1;
            SC_P2_FIRE:      hit[K_P2_FIRE]  = 1'b1;
            SC_START1_A:     hit[K_S1A]      = 1'b1;
            SC_START1_B:     hit[K_S1B]      = 1'b1;
            SC_START2_A:     hit[K_S2A]      = 1'b1;
            SC_START2_B:     hit[K_S2B]      = 1'b1;
            SC_COIN0:        hit[K_COIN0]    = 1'b1;
            SC_COIN1:        hit[K_COIN1]    = 1'b1;
            SC_TEST:         hit[K_TEST]     = 1'b1;
            default:         hit             = '0;
        endcase
        return hit;
    endfunction

    function automatic dir_t rot_dir(input dir_t d, input rot_e r);
        dir_t o;
        o = d;
        unique case (r)
            ROT_0:   o = d;
            ROT_90:  o = '{up: d.left,  down: d.right, left: d.down,  right: d.up};
            ROT_180: o = '{up: d.down,  down: d.up,    left: d.right, right: d.left};
            ROT_270: o = '{up: d.right, down: d.left,  left: d.up,    right: d.down};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Input/output bundle of the arcade input mapper.
interface arcade_input_mapper_if #(
    parameter int PLAYERS = 2
);
    logic [10:0]           ps2_key;
    logic [16*PLAYERS-1:0] joystick;
    logic [1:0]            rotate;
    logic [PLAYERS-1:0]    up;
    logic [PLAYERS-1:0]    down;
    logic [PLAYERS-1:0]    left;
    logic [PLAYERS-1:0]    right;
    logic [PLAYERS-1:0]    fire;
    logic [1:0]            start;
    logic [PLAYERS-1:0]    coin;
    logic                  test;

    modport master (
        output ps2_key, joystick, rotate,
        input  up, down, left, right, fire, start, coin, test
    );

    modport slave (
        input  ps2_key, joystick, rotate,
        output up, down, left, right, fire, start, coin, test
    );
endinterface

// File: rtl/arcade_coin_pulse.sv
// Per-player coin edge detector driving a fixed-length, non-retriggering
// coin pulse from a saturating down-counter.
module arcade_coin_pulse #(
    parameter int COIN_PULSE = 1200000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic req,
    output logic coin
);

    logic        req_q;
    logic [23:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_q <= 1'b0;
            cnt   <= '0;
            coin  <= 1'b0;
        end else begin
            req_q <= req;
            if (req && !req_q && !coin) begin
                coin <= 1'b1;
                cnt  <= 24'(COIN_PULSE - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - 24'd1;
            end else begin
                coin <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Keyboard/joystick merge, rotation and coin pulsing for arcade cores.
// Optional autofire is built in when ARCADE_AUTOFIRE_EN is defined.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int PLAYERS      = 2,
    parameter int COIN_PULSE   = 1200000,
    parameter int AUTOFIRE_DIV = 600000
) (
    input logic                  clk_sys,
    input logic                  reset,
    arcade_input_mapper_if.slave bus
);

    localparam logic [K_NUM-1:0] KEY_MASK =
        (PLAYERS >= 2) ? {K_NUM{1'b1}} : P1_ONLY_MASK;

    logic             tog_q;
    logic [K_NUM-1:0] key_q;
    logic [K_NUM-1:0] hit;

    assign hit = key_decode(bus.ps2_key[8:0]) & KEY_MASK;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q <= 1'b0;
            key_q <= '0;
        end else if (bus.ps2_key[10] != tog_q) begin
            tog_q <= bus.ps2_key[10];
            for (int k = 0; k < K_NUM; k++)
                if (hit[k]) key_q[k] <= bus.ps2_key[9];
        end
    end

`ifdef ARCADE_AUTOFIRE_EN
    logic [23:0] af_cnt;
    logic        af_phase;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == 24'(AUTOFIRE_DIV - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 24'd1;
        end
    end
`endif

    logic [PLAYERS-1:0] up_n, down_n, left_n, right_n, fire_n, coin_req;
    logic [1:0]         start_n;
    logic               unused_bits;

    always_comb begin
        dir_t raw, rd;
        logic f_raw;
        start_n     = {key_q[K_S2A] | key_q[K_S2B], key_q[K_S1A] | key_q[K_S1B]};
        unused_bits = 1'b0;
        up_n        = '0;
        down_n      = '0;
        left_n      = '0;
        right_n     = '0;
        fire_n      = '0;
        coin_req    = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            raw.up    = bus.joystick[16*p+JOY_UP];
            raw.down  = bus.joystick[16*p+JOY_DOWN];
            raw.left  = bus.joystick[16*p+JOY_LEFT];
            raw.right = bus.joystick[16*p+JOY_RIGHT];
            f_raw     = bus.joystick[16*p+JOY_FIRE];
            coin_req[p] = bus.joystick[16*p+JOY_COIN];
            if (p == 0) begin
                raw.up      |= key_q[K_P1_UP];
                raw.down    |= key_q[K_P1_DOWN];
                raw.left    |= key_q[K_P1_LEFT];
                raw.right   |= key_q[K_P1_RIGHT];
                f_raw       |= key_q[K_P1_FIREA] | key_q[K_P1_FIREB];
                coin_req[p] |= key_q[K_COIN0];
            end else if (p == 1) begin
                raw.up      |= key_q[K_P2_UP];
                raw.down    |= key_q[K_P2_DOWN];
                raw.left    |= key_q[K_P2_LEFT];
                raw.right   |= key_q[K_P2_RIGHT];
                f_raw       |= key_q[K_P2_FIRE];
                coin_req[p] |= key_q[K_COIN1];
            end
            rd = rot_dir(raw, rot_e'(bus.rotate));
            up_n[p]    = rd.up;
            down_n[p]  = rd.down;
            left_n[p]  = rd.left;
            right_n[p] = rd.right;
            start_n[0] |= bus.joystick[16*p+JOY_START];
            start_n[1] |= bus.joystick[16*p+JOY_START+1];
`ifdef ARCADE_AUTOFIRE_EN
            fire_n[p] = f_raw | (bus.joystick[16*p+JOY_AUTO] & af_phase);
`else
            fire_n[p] = f_raw;
            unused_bits ^= bus.joystick[16*p+JOY_AUTO];
`endif
            unused_bits ^= ^bus.joystick[16*p+9 +: 7];
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bus.up    <= '0;
            bus.down  <= '0;
            bus.left  <= '0;
            bus.right <= '0;
            bus.fire  <= '0;
            bus.start <= '0;
            bus.test  <= 1'b0;
        end else begin
            bus.up    <= up_n;
            bus.down  <= down_n;
            bus.left  <= left_n;
            bus.right <= right_n;
            bus.fire  <= fire_n;
            bus.start <= start_n;
            bus.test  <= key_q[K_TEST];
        end
    end

    logic [PLAYERS-1:0] coin_w;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        arcade_coin_pulse #(
            .COIN_PULSE (COIN_PULSE)
        ) u_coin (
            .clk_sys (clk_sys),
            .reset   (reset),
            .req     (coin_req[p]),
            .coin    (coin_w[p])
        );
    end

    assign bus.coin = coin_w;

endmodule
